// File: rtl/watchdog_pkg.sv
// Shared types and defaults for the watchdog timeout controller.
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_type;

  localparam int WDOG_CNT_W_DEFAULT    = 16;
  localparam int WDOG_PRESCALE_DEFAULT = 4;

endpackage

// File: rtl/watchdog_if.sv
// Control/status bundle between the register block and watchdog_ctrl.
interface watchdog_if
  import watchdog_pkg::*;
#(
  parameter int CNT_W = WDOG_CNT_W_DEFAULT
);
  logic             start_i;
  logic             stop_i;
  logic             kick_i;
  logic [CNT_W-1:0] timeout_i;
  logic [CNT_W-1:0] window_i;
  state_type        state_o;
  logic [CNT_W-1:0] count_o;
  logic             bark_o;
  logic             expired_o;
  logic             early_kick_o;

  modport master (
    output start_i, stop_i, kick_i, timeout_i, window_i,
    input  state_o, count_o, bark_o, expired_o, early_kick_o
  );

  modport slave (
    input  start_i, stop_i, kick_i, timeout_i, window_i,
    output state_o, count_o, bark_o, expired_o, early_kick_o
  );
endinterface

// File: rtl/wdog_prescaler.sv
// Divides clk by PRESCALE into single-cycle ticks while enabled; clear reloads
// the divider so the next tick lands a full PRESCALE cycles later.
module wdog_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LOAD = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = enable && (cnt_q == '0);
    if (clear) begin
      cnt_d = LOAD;
    end else if (enable) begin
      cnt_d = tick ? LOAD : cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/watchdog_ctrl.sv
// Watchdog timeout controller: reloadable down-counter on prescaled ticks with
// kick/expiry handling. Optional early-kick window enabled by WDOG_WINDOW_EN.
module watchdog_ctrl
  import watchdog_pkg::*;
#(
  parameter int CNT_W    = WDOG_CNT_W_DEFAULT,
  parameter int PRESCALE = WDOG_PRESCALE_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  watchdog_if.slave bus
);

  state_type        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             bark_q, bark_d;
  logic             expired_q, expired_d;
  logic             presc_clear;
  logic             tick;

`ifdef WDOG_WINDOW_EN
  logic [CNT_W-1:0] window_q, window_d;
  logic             early_q, early_d;
`else
  logic             unused_window;
  assign unused_window = ^bus.window_i;
`endif

  wdog_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .enable(state_q == RUN),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    bark_d      = 1'b0;
    expired_d   = expired_q;
    presc_clear = 1'b0;
`ifdef WDOG_WINDOW_EN
    window_d    = window_q;
    early_d     = 1'b0;
`endif

    if (bus.stop_i) begin
      state_d     = IDLE;
      count_d     = '0;
      expired_d   = 1'b0;
      presc_clear = 1'b1;
    end else if (bus.start_i && (bus.timeout_i != '0)) begin
      // Re-arming from DONE deliberately leaves expired set until stop.
      state_d     = RUN;
      reload_d    = bus.timeout_i;
      count_d     = bus.timeout_i;
      presc_clear = 1'b1;
`ifdef WDOG_WINDOW_EN
      window_d    = bus.window_i;
`endif
    end else if (state_q == RUN) begin
      if (bus.kick_i) begin
`ifdef WDOG_WINDOW_EN
        if ((window_q < reload_q) && (count_q > window_q)) begin
          state_d   = DONE;
          bark_d    = 1'b1;
          early_d   = 1'b1;
          expired_d = 1'b1;
        end else begin
          count_d     = reload_q;
          presc_clear = 1'b1;
        end
`else
        count_d     = reload_q;
        presc_clear = 1'b1;
`endif
      end else if (tick) begin
        if (count_q <= CNT_W'(1)) begin
          state_d   = DONE;
          count_d   = '0;
          bark_d    = 1'b1;
          expired_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      bark_q    <= 1'b0;
      expired_q <= 1'b0;
`ifdef WDOG_WINDOW_EN
      window_q  <= '0;
      early_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      bark_q    <= bark_d;
      expired_q <= expired_d;
`ifdef WDOG_WINDOW_EN
      window_q  <= window_d;
      early_q   <= early_d;
`endif
    end
  end

  assign bus.state_o   = state_q;
  assign bus.count_o   = count_q;
  assign bus.bark_o    = bark_q;
  assign bus.expired_o = expired_q;
`ifdef WDOG_WINDOW_EN
  assign bus.early_kick_o = early_q;
`else
  assign bus.early_kick_o = 1'b0;
`endif

endmodule

// File: doc/watchdog_ctrl.md
# watchdog_ctrl

Timeout controller for the watchdog: arms a down-counter from a programmed reload value, decrements it on prescaled ticks, restarts it on software kicks, and flags expiry. Sequences through the shared `state_type` (IDLE/RUN/DONE) from `watchdog_pkg`. Sits between the register/control interface (start/stop/kick, reload value) and the reset/interrupt logic that consumes `bark_o`/`expired_o`.

## Interface
- `CNT_W`, 16, width of the timeout counter and reload value.
- `PRESCALE`, 4, clock cycles per counter tick; integer ≥ 1.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  arm the watchdog; samples `timeout_i`/`window_i`.
- `stop_i`  in  1  disarm; return to IDLE, clear sticky flags.
- `kick_i`  in  1  service pulse; reload counter.
- `timeout_i`  in  CNT_W  reload value in ticks, unsigned.
- `window_i`  in  CNT_W  early-kick threshold, unsigned; only used with `WDOG_WINDOW_EN`.
- `state_o`  out  2  current `state_type`.
- `count_o`  out  CNT_W  remaining ticks.
- `bark_o`  out  1  one-cycle expiry/fault pulse.
- `expired_o`  out  1  sticky expiry flag.
- `early_kick_o`  out  1  one-cycle early-kick pulse.

## Operation
- Reset: `state_o`=IDLE, `count_o`=0, `bark_o`=0, `expired_o`=0, `early_kick_o`=0, prescaler=PRESCALE-1, reload/window registers=0.
- Command priority per cycle: `rst` > `stop_i` > `start_i` > `kick_i` > tick.
- IDLE: `start_i` with `timeout_i`≠0 → latch reload=`timeout_i`, window=`window_i`, count=reload, prescaler=PRESCALE-1, go RUN. `start_i` with `timeout_i`=0 ignored. `kick_i` ignored.
- RUN: prescaler decrements each cycle; at 0 a tick occurs and prescaler reloads PRESCALE-1. On tick, count decrements. Tick with count=1 → count 0, go DONE, `bark_o`=1, `expired_o`=1.
- Kick in RUN: count=reload, prescaler=PRESCALE-1. Kick coincident with the expiring tick wins: no bark, stay RUN.
- `start_i` in RUN: re-latch reload/window, restart counter as from IDLE.
- DONE: count holds 0, `expired_o` held. `kick_i` ignored. `start_i` re-arms to RUN (`expired_o` stays set). `stop_i` → IDLE, clears `expired_o`.
- `stop_i` in any state: IDLE, count=0, prescaler=PRESCALE-1, `expired_o`=0.
- Counter never wraps: no decrement below 0.

## Timing
- All outputs registered. Start sampled at edge ending cycle 0: RUN, count=T visible cycle 1.
- With P=PRESCALE: count=T-n visible at cycle 1+n·P; DONE, count=0, `bark_o`=1 visible at cycle 1+T·P, `bark_o` low next cycle.
- Kick sampled in cycle k: count=reload visible cycle k+1; next decrement visible cycle k+1+P.
- PRESCALE=1: tick every RUN cycle.
- Stop sampled in cycle k: IDLE, flags clear, visible cycle k+1.

## Configuration
- `WDOG_WINDOW_EN` defined: kick in RUN while count > latched window is early → `early_kick_o`=1 and `bark_o`=1 for one cycle, `expired_o`=1, go DONE, count held at its current value. Kick with count ≤ window is normal. Window ≥ reload disables the check (every kick is normal).
- Undefined: `window_i` ignored, no window register, `early_kick_o` tied 0; every RUN kick is normal.

## Structure
- `state_type` stays in `watchdog_pkg`. Add to `watchdog_pkg`: `WDOG_CNT_W_DEFAULT`=16, `WDOG_PRESCALE_DEFAULT`=4.
- Sub-module `wdog_prescaler`: PRESCALE-cycle tick generator with `clear` and `enable` inputs and a `tick` output. Everything else (FSM, counter, flags) in `watchdog_ctrl`.

## Test plan
- Reset then idle: all outputs 0, state IDLE; `kick_i`=1 and `start_i` with `timeout_i`=0 → no change.
- PRESCALE=4, start with T=3 at cycle 0 → count 3/2/1 at cycles 1/5/9, DONE with `bark_o` one cycle at cycle 13, `expired_o` held until `stop_i`.
- T=3, kick in the cycle of the final tick → no bark, count=3 next cycle, RUN continues; periodic kicks every 8 cycles → never expires.
- `stop_i` and `kick_i` together mid-RUN → IDLE, count 0; `rst` asserted mid-RUN → reset values next cycle.
- `WDOG_WINDOW_EN`, T=10, window=4, kick at count=7 → `early_kick_o`=`bark_o`=1, DONE, count 7; re-arm, kick at count=4 → normal reload to 10.
- PRESCALE=1, T=1: start → RUN count 1 at cycle 1, DONE + bark at cycle 2; `start_i` in DONE → RUN count=T, `expired_o` still 1.
